code_lock_ctrl: RTL and testbench

CODE_LOCK_CTRL -- requirements
Module: code_lock_ctrl

---
 rtl/code_lock_ctrl.sv | 150 +++++++++++++++
 tb/tb_code_lock_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/code_lock_ctrl.sv
// Digit-entry code lock: collects DIGITS entries on enter rising edges, compares the whole code
// at once, shows the result on a packed display and enforces a timed lockout after repeated failures.
module code_lock_ctrl #(
  parameter int unsigned                   DIGITS      = 4,
  parameter int unsigned                   SW_W        = 4,
  parameter logic [DIGITS*SW_W-1:0]        CODE        = 16'h0485,
  parameter int unsigned                   MAX_TRIES   = 3,
  parameter int unsigned                   LOCK_CYCLES = 1000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enter,
  input  logic [SW_W-1:0]             sw,
  output logic [DIGITS*(SW_W+1)-1:0]  seg_wr,
  output logic                        unlocked,
  output logic                        locked_out,
  output logic [3:0]                  tries_left
);

  localparam int unsigned SEG_W = SW_W + 1;
  localparam int unsigned BUF_W = DIGITS * SW_W;
  localparam int unsigned IDX_W = $clog2(DIGITS);
  localparam int unsigned CNT_W = $clog2(LOCK_CYCLES);

  localparam logic [SEG_W-1:0] BLANK      = {1'b1, {SW_W{1'b0}}};
  localparam logic [SEG_W-1:0] ERR        = {1'b0, {SW_W{1'b1}}};
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [3:0]       TRIES_INIT = 4'(MAX_TRIES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENTRY   = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [BUF_W-1:0]         buf_q, buf_d;
  logic [DIGITS*SEG_W-1:0]  seg_q, seg_d;
  logic                     unlocked_q, unlocked_d;
  logic                     locked_q, locked_d;
  logic [3:0]               tries_q, tries_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     enter_q, enter_d;
  logic                     arm_q, arm_d;
  logic                     edge_c;
  logic [BUF_W-1:0]         entry_c;

  // State register; arm_q blocks a spurious edge when enter is held high across reset release
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      buf_q      <= '0;
      seg_q      <= {DIGITS{BLANK}};
      unlocked_q <= 1'b0;
      locked_q   <= 1'b0;
      tries_q    <= TRIES_INIT;
      cnt_q      <= '0;
      enter_q    <= 1'b0;
      arm_q      <= ~enter;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      buf_q      <= buf_d;
      seg_q      <= seg_d;
      unlocked_q <= unlocked_d;
      locked_q   <= locked_d;
      tries_q    <= tries_d;
      cnt_q      <= cnt_d;
      enter_q    <= enter_d;
      arm_q      <= arm_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    buf_d      = buf_q;
    seg_d      = seg_q;
    unlocked_d = unlocked_q;
    locked_d   = locked_q;
    tries_d    = tries_q;
    cnt_d      = cnt_q;
    enter_d    = enter;
    arm_d      = arm_q | ~enter;
    edge_c     = enter & ~enter_q & arm_q;
    entry_c    = {buf_q[BUF_W-1:SW_W], sw};

    case (state_q)
      ST_IDLE, ST_ENTRY: begin
        if (edge_c) begin
          if (idx_q != IDX_LAST) begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
              if (IDX_W'(DIGITS - 1 - i) == idx_q) buf_d[i*SW_W +: SW_W] = sw;
            end
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_ENTRY;
            if (state_q == ST_IDLE) begin
              seg_d      = {DIGITS{BLANK}};
              unlocked_d = 1'b0;
            end
          end else begin
            buf_d[SW_W-1:0] = sw;
            idx_d           = '0;
            state_d         = ST_IDLE;
            if (entry_c == CODE) begin
              for (int unsigned i = 0; i < DIGITS; i++) begin
                seg_d[i*SEG_W +: SEG_W] = {1'b0, entry_c[i*SW_W +: SW_W]};
              end
              unlocked_d = 1'b1;
              tries_d    = TRIES_INIT;
            end else begin
              seg_d      = {DIGITS{ERR}};
              unlocked_d = 1'b0;
              if (tries_q > 4'd1) begin
                tries_d = tries_q - 4'd1;
              end else begin
                tries_d  = '0;
                locked_d = 1'b1;
                cnt_d    = CNT_LOAD;
                state_d  = ST_LOCKOUT;
              end
            end
          end
        end
      end
      ST_LOCKOUT: begin
        // Edges are ignored here; expiry lands LOCK_CYCLES cycles after entry
        if (cnt_q == '0) begin
          state_d  = ST_IDLE;
          locked_d = 1'b0;
          tries_d  = TRIES_INIT;
          seg_d    = {DIGITS{BLANK}};
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign seg_wr     = seg_q;
  assign unlocked   = unlocked_q;
  assign locked_out = locked_q;
  assign tries_left = tries_q;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Bench for code_lock_ctrl: cycle-level behavioural model of the default lock plus literal
// expectations, and a second 6-digit, 3-bit instance checked against hand-computed values.
module tb_code_lock_ctrl;

  logic        clk = 1'b0;
  logic        rst, enter;
  logic [3:0]  sw;
  logic [19:0] seg_a;
  logic        unl_a, lck_a;
  logic [3:0]  tries_a;

  logic        rst_b, enter_b;
  logic [2:0]  sw_b;
  logic [23:0] seg_b;
  logic        unl_b, lck_b;
  logic [3:0]  tries_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  code_lock_ctrl dut_a (
    .clk(clk), .rst(rst), .enter(enter), .sw(sw),
    .seg_wr(seg_a), .unlocked(unl_a), .locked_out(lck_a), .tries_left(tries_a)
  );

  code_lock_ctrl #(.DIGITS(6), .SW_W(3), .CODE(18'o123456)) dut_b (
    .clk(clk), .rst(rst_b), .enter(enter_b), .sw(sw_b),
    .seg_wr(seg_b), .unlocked(unl_b), .locked_out(lck_b), .tries_left(tries_b)
  );

  // Behavioural model of the default instance: entered digits kept in a queue,
  // lockout expiry scheduled as an absolute cycle number.
  int  m_disp[4];
  bit  m_unl = 0, m_lock = 0, m_prev = 0, m_armed = 0;
  int  m_tries = 3;
  int  digs[$];
  int  cyc = 0, exit_cyc = 0;

  always @(posedge clk) begin
    bit e;
    int val;
    cyc++;
    if (rst) begin
      foreach (m_disp[j]) m_disp[j] = 16;
      m_unl = 0; m_lock = 0; m_tries = 3; m_prev = 0; m_armed = !enter;
      digs.delete();
    end else begin
      e = enter && !m_prev && m_armed;
      m_armed = m_armed || !enter;
      m_prev  = enter;
      if (m_lock) begin
        if (cyc == exit_cyc) begin
          m_lock = 0; m_tries = 3;
          foreach (m_disp[j]) m_disp[j] = 16;
        end
      end else if (e) begin
        if (digs.size() == 0) begin
          foreach (m_disp[j]) m_disp[j] = 16;
          m_unl = 0;
        end
        digs.push_back(int'(sw));
        if (digs.size() == 4) begin
          val = 0;
          foreach (digs[j]) val = val * 16 + digs[j];
          if (val == 'h0485) begin
            foreach (digs[j]) m_disp[3-j] = digs[j];
            m_unl = 1; m_tries = 3;
          end else begin
            foreach (m_disp[j]) m_disp[j] = 15;
            m_unl = 0;
            if (m_tries > 1) m_tries--;
            else begin
              m_tries = 0; m_lock = 1; exit_cyc = cyc + 1000;
            end
          end
          digs.delete();
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: wait for the falling edge and compare the default instance with the model
  task automatic cyc1();
    logic [19:0] exp_seg;
    @(negedge clk);
    for (int j = 0; j < 4; j++) exp_seg[j*5 +: 5] = 5'(m_disp[j]);
    chk("model_seg", 64'(seg_a), 64'(exp_seg));
    chk("model_unlocked", 64'(unl_a), 64'(m_unl));
    chk("model_locked_out", 64'(lck_a), 64'(m_lock));
    chk("model_tries", 64'(tries_a), 64'(m_tries));
  endtask

  task automatic press(input logic [3:0] d);
    sw = d; enter = 1'b1; cyc1();
    enter = 1'b0; cyc1();
  endtask

  task automatic code4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    press(a); press(b); press(c); press(d);
  endtask

  task automatic press_b(input logic [2:0] d);
    sw_b = d; enter_b = 1'b1; cyc1();
    enter_b = 1'b0; cyc1();
  endtask

  localparam logic [19:0] A_BLANK = {4{5'd16}};
  localparam logic [19:0] A_ERR   = {4{5'd15}};
  localparam logic [19:0] A_OPEN  = {5'd0, 5'd4, 5'd8, 5'd5};

  initial begin
    rst = 1'b1; enter = 1'b0; sw = '0;
    rst_b = 1'b1; enter_b = 1'b0; sw_b = '0;
    repeat (3) cyc1();
    chk("reset_seg", 64'(seg_a), 64'(A_BLANK));
    chk("reset_tries", 64'(tries_a), 64'd3);
    chk("reset_unlocked", 64'(unl_a), 64'd0);
    rst = 1'b0; rst_b = 1'b0;
    cyc1();

    code4(4'd0, 4'd4, 4'd8, 4'd5);
    chk("open_seg", 64'(seg_a), 64'(A_OPEN));
    chk("open_unlocked", 64'(unl_a), 64'd1);
    chk("open_tries", 64'(tries_a), 64'd3);

    press(4'd1);
    chk("first_digit_blanks", 64'(seg_a), 64'(A_BLANK));
    chk("first_digit_drops_unlock", 64'(unl_a), 64'd0);
    press(4'd2); press(4'd3); press(4'd4);
    chk("wrong1_tries", 64'(tries_a), 64'd2);

    code4(4'd0, 4'd4, 4'd8, 4'd6);
    chk("wrong2_seg", 64'(seg_a), 64'(A_ERR));
    chk("wrong2_unlocked", 64'(unl_a), 64'd0);
    chk("wrong2_tries", 64'(tries_a), 64'd1);
    code4(4'd9, 4'd9, 4'd9, 4'd9);
    chk("lockout_flag", 64'(lck_a), 64'd1);
    chk("lockout_tries", 64'(tries_a), 64'd0);
    code4(4'd0, 4'd4, 4'd8, 4'd5);
    chk("lockout_ignores_code", 64'(unl_a), 64'd0);
    chk("lockout_still_err", 64'(seg_a), 64'(A_ERR));
    repeat (988) cyc1();
    chk("lockout_before_expiry", 64'(lck_a), 64'd1);
    repeat (12) cyc1();
    chk("lockout_expired", 64'(lck_a), 64'd0);
    chk("lockout_exit_seg", 64'(seg_a), 64'(A_BLANK));
    chk("lockout_exit_tries", 64'(tries_a), 64'd3);

    // Held enter: a second accepted zero would make the next three digits mismatch
    sw = 4'd0; enter = 1'b1;
    repeat (50) cyc1();
    enter = 1'b0; cyc1();
    press(4'd4); press(4'd8); press(4'd5);
    chk("held_one_digit", 64'(unl_a), 64'd1);
    chk("held_seg", 64'(seg_a), 64'(A_OPEN));

    code4(4'd7, 4'd7, 4'd7, 4'd7);
    press(4'd1); press(4'd2);
    rst = 1'b1; cyc1(); rst = 1'b0; cyc1();
    chk("rst_mid_entry_seg", 64'(seg_a), 64'(A_BLANK));
    chk("rst_mid_entry_tries", 64'(tries_a), 64'd3);
    code4(4'd0, 4'd4, 4'd8, 4'd5);
    chk("rst_mid_entry_reopen", 64'(unl_a), 64'd1);

    repeat (3) code4(4'd1, 4'd1, 4'd1, 4'd1);
    repeat (20) cyc1();
    chk("pre_rst_locked", 64'(lck_a), 64'd1);
    rst = 1'b1; cyc1(); rst = 1'b0; cyc1();
    chk("rst_mid_lock_flag", 64'(lck_a), 64'd0);
    chk("rst_mid_lock_seg", 64'(seg_a), 64'(A_BLANK));
    chk("rst_mid_lock_tries", 64'(tries_a), 64'd3);
    code4(4'd0, 4'd4, 4'd8, 4'd5);
    chk("rst_mid_lock_reopen", 64'(unl_a), 64'd1);

    // Enter held through reset release must not count as a digit
    sw = 4'd9; enter = 1'b1; rst = 1'b1; cyc1();
    rst = 1'b0; repeat (3) cyc1();
    enter = 1'b0; cyc1();
    code4(4'd0, 4'd4, 4'd8, 4'd5);
    chk("held_through_reset", 64'(unl_a), 64'd1);
    chk("held_through_reset_seg", 64'(seg_a), 64'(A_OPEN));

    // Six-digit, three-bit instance
    chk("b_reset_seg", 64'(seg_b), 64'({6{4'd8}}));
    press_b(3'd1);
    chk("b_mid_entry_blank", 64'(seg_b), 64'({6{4'd8}}));
    press_b(3'd2); press_b(3'd3); press_b(3'd4); press_b(3'd5); press_b(3'd7);
    chk("b_wrong_seg", 64'(seg_b), 64'({6{4'd7}}));
    chk("b_wrong_tries", 64'(tries_b), 64'd2);
    press_b(3'd1); press_b(3'd2); press_b(3'd3); press_b(3'd4); press_b(3'd5); press_b(3'd6);
    chk("b_open_seg", 64'(seg_b), 64'({4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6}));
    chk("b_open_unlocked", 64'(unl_b), 64'd1);
    chk("b_open_tries", 64'(tries_b), 64'd3);
    chk("b_locked_out", 64'(lck_b), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
